// File: rtl/seq_timing_gen.sv
// Sequence counter and one-hot timing generator feeding the control unit; run/halt/step control.
// Latency: one cycle from START/HALT/STEP_REQ/CLRSEQ/INCSEQ to registered T/SC/STEP_ACK/INSTR_CNT.
// No backpressure: CLRSEQ/INCSEQ are honoured only in RUN; optional watchdog via SEQ_WATCHDOG_EN.
module seq_timing_gen #(
    parameter int CNT_W    = 16,
    parameter int WD_LIMIT = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             HALT,
    input  logic             STEP_MODE,
    input  logic             STEP_REQ,
    input  logic             CLRSEQ,
    input  logic             INCSEQ,
    output logic [7:0]       T,
    output logic [2:0]       SC,
    output logic             RUNNING,
    output logic             STEP_ACK,
    output logic [CNT_W-1:0] INSTR_CNT,
    output logic             SEQ_ERR
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STEP_WAIT = 2'd2,
        HALTED    = 2'd3
    } state_t;

    state_t     state;
    logic       halt_pend;
    // Set when a step is acknowledged; a new request needs STEP_REQ to drop first.
    logic       req_block;
    logic [2:0] sc_inc;

    assign sc_inc  = SC + 3'd1;
    assign RUNNING = (state == RUN);

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    // Watchdog limit has no effect in this build.
    logic [31:0] unused_wd_limit;
    assign unused_wd_limit = 32'(WD_LIMIT);
`endif

    // Control FSM with all outputs registered; T always tracks 1<<SC while in RUN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            SC        <= 3'd0;
            T         <= 8'h00;
            STEP_ACK  <= 1'b0;
            INSTR_CNT <= '0;
            SEQ_ERR   <= 1'b0;
            halt_pend <= 1'b0;
            req_block <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
        end else begin
            STEP_ACK <= 1'b0;
            if (!STEP_REQ) begin
                req_block <= 1'b0;
            end
`ifdef SEQ_WATCHDOG_EN
            wd_cnt <= '0;
`endif
            case (state)
                IDLE, HALTED: begin
                    SC <= 3'd0;
                    T  <= 8'h00;
                    if (START) begin
                        state <= RUN;
                        T     <= 8'h01;
                    end
                end
                RUN: begin
                    if (CLRSEQ) begin
                        // Instruction boundary: retire, then decide where to go next.
                        SC <= 3'd0;
                        T  <= 8'h01;
                        if (INSTR_CNT != '1) begin
                            INSTR_CNT <= INSTR_CNT + CNT_W'(1);
                        end
                        if (halt_pend || HALT) begin
                            state     <= HALTED;
                            halt_pend <= 1'b0;
                            T         <= 8'h00;
                        end else if (STEP_MODE) begin
                            state <= STEP_WAIT;
                            T     <= 8'h00;
                        end
                    end else begin
                        if (HALT) begin
                            halt_pend <= 1'b1;
                        end
                        if (INCSEQ) begin
                            SC <= sc_inc;
                            T  <= 8'h01 << sc_inc;
                            if (SC == 3'd7) begin
                                SEQ_ERR <= 1'b1;
                            end
                        end else begin
`ifdef SEQ_WATCHDOG_EN
                            // Stalled sequence: restart at T0 once the idle limit is hit.
                            if (wd_cnt == WD_W'(WD_LIMIT - 1)) begin
                                SC      <= 3'd0;
                                T       <= 8'h01;
                                SEQ_ERR <= 1'b1;
                            end else begin
                                wd_cnt <= wd_cnt + WD_W'(1);
                            end
`endif
                        end
                    end
                end
                STEP_WAIT: begin
                    SC <= 3'd0;
                    T  <= 8'h00;
                    if (HALT) begin
                        halt_pend <= 1'b1;
                    end
                    if (!STEP_MODE) begin
                        state <= RUN;
                        T     <= 8'h01;
                    end else if (STEP_REQ && !req_block) begin
                        state     <= RUN;
                        T         <= 8'h01;
                        STEP_ACK  <= 1'b1;
                        req_block <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
